// File: rtl/infer_mul_arb_if.sv
// rtl/infer_mul_arb_if.sv - requester, response and multiplier-core bus of infer_mul_arb
interface infer_mul_arb_if #(
    parameter int N_REQ = 4
) ();
    logic [N_REQ-1:0]    req_valid;
    logic [21*N_REQ-1:0] req_a;
    logic [14*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    rsp_valid;
    logic [34:0]         rsp_p;
    logic [N_REQ-1:0]    rsp_ready;
    logic                mul_ce;
    logic [20:0]         mul_din0;
    logic [13:0]         mul_din1;
    logic [34:0]         mul_dout;
    logic                busy;

    modport master (
        input  req_valid, req_a, req_b, rsp_ready, mul_dout,
        output req_ready, rsp_valid, rsp_p, mul_ce, mul_din0, mul_din1, busy
    );

    modport slave (
        output req_valid, req_a, req_b, rsp_ready, mul_dout,
        input  req_ready, rsp_valid, rsp_p, mul_ce, mul_din0, mul_din1, busy
    );
endinterface

// File: rtl/infer_mul_arb.sv
// rtl/infer_mul_arb.sv - round-robin share of one pipelined 21s x 14s multiplier core
// A tag pipeline runs in lockstep with the core so each product returns to its requester.
module infer_mul_arb #(
    parameter int N_REQ   = 4,
    parameter int IDW     = 2,
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             reset,
    infer_mul_arb_if.master  bus
);
    logic [MUL_LAT-1:0] r_vld;
    logic [IDW-1:0]     r_tag [MUL_LAT];
    logic [IDW-1:0]     r_ptr;

    logic [N_REQ-1:0]   w_rsp_valid;
    logic [N_REQ-1:0]   w_ready;
    logic               w_ce;
    logic               w_found;
    logic               w_grant;
    logic [IDW-1:0]     w_win;
    logic [IDW-1:0]     w_cand;

    always_comb begin
        w_rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_vld[MUL_LAT-1] && (r_tag[MUL_LAT-1] == IDW'(i))) begin
                w_rsp_valid[i] = 1'b1;
            end
        end
    end

    // The whole core freezes while the output product waits on its consumer.
    assign w_ce = ~|(w_rsp_valid & ~bus.rsp_ready);

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = IDW'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // Reset gating keeps req_ready low for the whole time reset is held.
    assign w_grant = w_found & w_ce & reset;

    always_comb begin
        w_ready = '0;
        if (w_grant) begin
            w_ready[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                r_tag[i] <= '0;
            end
            r_ptr <= IDW'(N_REQ - 1);
        end else if (w_ce) begin
            r_vld[0] <= w_grant;
            r_tag[0] <= w_win;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
            if (w_grant) begin
                r_ptr <= w_win;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_p     = bus.mul_dout;
    assign bus.mul_ce    = w_ce;
    assign bus.mul_din0  = w_grant ? bus.req_a[int'(w_win)*21 +: 21] : 21'd0;
    assign bus.mul_din1  = w_grant ? bus.req_b[int'(w_win)*14 +: 14] : 14'd0;
    assign bus.busy      = |r_vld;
endmodule

// File: tb/tb_infer_mul_arb.sv
// tb/tb_infer_mul_arb.sv - vector table, directed corner sequences and scoreboarded soak for infer_mul_arb
module tb_infer_mul_arb;
    localparam int N = 4;
    localparam int L = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    infer_mul_arb_if #(.N_REQ(N)) bus ();

    infer_mul_arb #(.N_REQ(N), .IDW(2), .MUL_LAT(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic signed [34:0] smul(input logic signed [20:0] a, input logic signed [13:0] b);
        logic signed [34:0] x;
        logic signed [34:0] y;
        x = a;
        y = b;
        return x * y;
    endfunction

    // Behavioural stand-in for the clock-enabled core: no reset, L enabled edges of latency.
    logic signed [34:0] core_p [L];
    always @(posedge clk) begin
        if (bus.mul_ce) begin
            core_p[0] <= smul(bus.mul_din0, bus.mul_din1);
            for (int i = 1; i < L; i++) core_p[i] <= core_p[i-1];
        end
    end
    assign bus.mul_dout = core_p[L-1];

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [34:0] p35(input longint v);
        return v[34:0];
    endfunction

    function automatic logic [83:0] pa(input int a0, input int a1, input int a2, input int a3);
        return {a3[20:0], a2[20:0], a1[20:0], a0[20:0]};
    endfunction

    function automatic logic [55:0] pb(input int b0, input int b1, input int b2, input int b3);
        return {b3[13:0], b2[13:0], b1[13:0], b0[13:0]};
    endfunction

    task automatic drive(input logic rst, input logic [3:0] v, input logic [83:0] a,
                         input logic [55:0] b, input logic [3:0] rr);
        @(posedge clk);
        #1;
        reset         = rst;
        bus.req_valid = v;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.rsp_ready = rr;
        @(negedge clk);
    endtask

    typedef struct packed {
        logic        rst_n;
        logic [3:0]  v;
        logic [83:0] a;
        logic [55:0] b;
        logic [3:0]  e_rdy;
        logic [3:0]  e_rv;
        logic [34:0] e_p;
        logic        e_busy;
        logic [20:0] e_d0;
        logic [13:0] e_d1;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [83:0] a,
                                input logic [55:0] b, input logic [3:0] er, input logic [3:0] ev,
                                input longint p, input logic eb, input int d0, input int d1);
        vec_t r;
        r.rst_n  = rst;
        r.v      = v;
        r.a      = a;
        r.b      = b;
        r.e_rdy  = er;
        r.e_rv   = ev;
        r.e_p    = p35(p);
        r.e_busy = eb;
        r.e_d0   = d0[20:0];
        r.e_d1   = d1[13:0];
        return r;
    endfunction

    typedef struct {
        int     tag;
        longint prod;
        int     age;
    } fl_t;

    vec_t        tbl [19];
    logic [83:0] ta;
    logic [55:0] tb_b;
    logic [83:0] ra;
    logic [55:0] rb;
    logic [3:0]  v;
    logic [3:0]  rr;
    fl_t         q [$];
    int          gcnt [N];
    int          mptr;

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '1;

        ta   = pa(-1048576, 0, 0, 0);
        tb_b = pb(-8192, 0, 0, 0);
        ra   = pa(1, 2, 3, 4);
        rb   = pb(100, 100, 100, 100);
        tbl[0]  = mk(0, 4'b0001, ta, tb_b, 4'b0000, 4'b0000, 0, 0, 0, 0);
        tbl[1]  = mk(1, 4'b0001, ta, tb_b, 4'b0001, 4'b0000, 0, 0, -1048576, -8192);
        tbl[2]  = mk(1, 4'b0000, ta, tb_b, 4'b0000, 4'b0000, 0, 1, 0, 0);
        tbl[3]  = mk(1, 4'b0000, ta, tb_b, 4'b0000, 4'b0000, 0, 1, 0, 0);
        tbl[4]  = mk(1, 4'b0000, ta, tb_b, 4'b0000, 4'b0001, 64'sd8589934592, 1, 0, 0);
        tbl[5]  = mk(1, 4'b0000, ta, tb_b, 4'b0000, 4'b0000, 0, 0, 0, 0);
        tbl[6]  = mk(0, 4'b0000, ra, rb, 4'b0000, 4'b0000, 0, 0, 0, 0);
        tbl[7]  = mk(1, 4'b1111, ra, rb, 4'b0001, 4'b0000, 0, 0, 1, 100);
        tbl[8]  = mk(1, 4'b1111, ra, rb, 4'b0010, 4'b0000, 0, 1, 2, 100);
        tbl[9]  = mk(1, 4'b1111, ra, rb, 4'b0100, 4'b0000, 0, 1, 3, 100);
        tbl[10] = mk(1, 4'b1111, ra, rb, 4'b1000, 4'b0001, 100, 1, 4, 100);
        tbl[11] = mk(1, 4'b1111, ra, rb, 4'b0001, 4'b0010, 200, 1, 1, 100);
        tbl[12] = mk(1, 4'b1111, ra, rb, 4'b0010, 4'b0100, 300, 1, 2, 100);
        tbl[13] = mk(1, 4'b1111, ra, rb, 4'b0100, 4'b1000, 400, 1, 3, 100);
        tbl[14] = mk(1, 4'b1111, ra, rb, 4'b1000, 4'b0001, 100, 1, 4, 100);
        tbl[15] = mk(1, 4'b0000, ra, rb, 4'b0000, 4'b0010, 200, 1, 0, 0);
        tbl[16] = mk(1, 4'b0000, ra, rb, 4'b0000, 4'b0100, 300, 1, 0, 0);
        tbl[17] = mk(1, 4'b0000, ra, rb, 4'b0000, 4'b1000, 400, 1, 0, 0);
        tbl[18] = mk(1, 4'b0000, ra, rb, 4'b0000, 4'b0000, 0, 0, 0, 0);

        // Reset state, first operation latency, and round-robin order.
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst_n, tbl[i].v, tbl[i].a, tbl[i].b, 4'hF);
            check($sformatf("tbl%0d req_ready", i), bus.req_ready, tbl[i].e_rdy);
            check($sformatf("tbl%0d rsp_valid", i), bus.rsp_valid, tbl[i].e_rv);
            if (tbl[i].e_rv != 4'b0000)
                check($sformatf("tbl%0d rsp_p", i), bus.rsp_p, tbl[i].e_p);
            check($sformatf("tbl%0d mul_ce", i), bus.mul_ce, 1'b1);
            check($sformatf("tbl%0d busy", i), bus.busy, tbl[i].e_busy);
            check($sformatf("tbl%0d din0", i), bus.mul_din0, tbl[i].e_d0);
            check($sformatf("tbl%0d din1", i), bus.mul_din1, tbl[i].e_d1);
        end

        // Backpressure: req1's consumer stalls for five cycles once its product appears.
        ta   = pa(0, -5, 1000, 2);
        tb_b = pb(0, 7, -3, 2);
        drive(1, 4'b0110, ta, tb_b, 4'hF);
        check("bp grant1", bus.req_ready, 4'b0010);
        drive(1, 4'b0100, ta, tb_b, 4'hF);
        check("bp grant2", bus.req_ready, 4'b0100);
        drive(1, 4'b0000, ta, tb_b, 4'hF);
        check("bp idle", bus.req_ready, 4'b0000);
        for (int c = 0; c < 5; c++) begin
            drive(1, 4'b1000, ta, tb_b, 4'b1101);
            check($sformatf("bp%0d mul_ce", c), bus.mul_ce, 1'b0);
            check($sformatf("bp%0d req_ready", c), bus.req_ready, 4'b0000);
            check($sformatf("bp%0d rsp_valid", c), bus.rsp_valid, 4'b0010);
            check($sformatf("bp%0d rsp_p", c), bus.rsp_p, p35(-35));
            check($sformatf("bp%0d busy", c), bus.busy, 1'b1);
        end
        drive(1, 4'b1000, ta, tb_b, 4'hF);
        check("bp release rsp_valid", bus.rsp_valid, 4'b0010);
        check("bp release rsp_p", bus.rsp_p, p35(-35));
        check("bp release mul_ce", bus.mul_ce, 1'b1);
        check("bp release grant3", bus.req_ready, 4'b1000);
        drive(1, 4'b0000, ta, tb_b, 4'hF);
        check("bp req2 rsp_valid", bus.rsp_valid, 4'b0100);
        check("bp req2 rsp_p", bus.rsp_p, p35(-3000));
        drive(1, 4'b0000, ta, tb_b, 4'hF);
        check("bp bubble rsp_valid", bus.rsp_valid, 4'b0000);
        drive(1, 4'b0000, ta, tb_b, 4'hF);
        check("bp req3 rsp_valid", bus.rsp_valid, 4'b1000);
        check("bp req3 rsp_p", bus.rsp_p, p35(4));
        drive(1, 4'b0000, ta, tb_b, 4'hF);
        check("bp drained busy", bus.busy, 1'b0);
        check("bp drained rsp_valid", bus.rsp_valid, 4'b0000);

        // Bubbles: req3 every third cycle with b=0.
        ta   = pa(0, 0, 0, 12345);
        tb_b = pb(0, 0, 0, 0);
        for (int k = 0; k < 14; k++) begin
            v = ((k % 3 == 0) && (k < 12)) ? 4'b1000 : 4'b0000;
            drive(1, v, ta, tb_b, 4'hF);
            check($sformatf("bub%0d req_ready", k), bus.req_ready, v);
            check($sformatf("bub%0d rsp_valid", k), bus.rsp_valid,
                  ((k >= 3) && (k % 3 == 0)) ? 4'b1000 : 4'b0000);
            if ((k >= 3) && (k % 3 == 0))
                check($sformatf("bub%0d rsp_p", k), bus.rsp_p, 35'd0);
            check($sformatf("bub%0d busy", k), bus.busy, (k >= 1) && (k <= 12));
        end

        // Asynchronous reset pulse with three products in flight.
        ta   = pa(11, 22, 33, 44);
        tb_b = pb(1, 1, 1, 1);
        drive(1, 4'b0001, ta, tb_b, 4'hF);
        check("rst grant0", bus.req_ready, 4'b0001);
        drive(1, 4'b0010, ta, tb_b, 4'hF);
        check("rst grant1", bus.req_ready, 4'b0010);
        drive(1, 4'b0100, ta, tb_b, 4'hF);
        check("rst grant2", bus.req_ready, 4'b0100);
        @(posedge clk);
        #1;
        bus.req_valid = 4'b0000;
        reset = 1'b0;
        #1;
        check("rst pulse busy", bus.busy, 1'b0);
        check("rst pulse rsp_valid", bus.rsp_valid, 4'b0000);
        check("rst pulse req_ready", bus.req_ready, 4'b0000);
        check("rst pulse mul_ce", bus.mul_ce, 1'b1);
        #2;
        reset = 1'b1;
        @(negedge clk);
        check("rst after rsp_valid", bus.rsp_valid, 4'b0000);
        for (int c = 0; c < 4; c++) begin
            drive(1, 4'b0000, ta, tb_b, 4'hF);
            check($sformatf("rst quiet%0d rsp_valid", c), bus.rsp_valid, 4'b0000);
            check($sformatf("rst quiet%0d busy", c), bus.busy, 1'b0);
        end
        drive(1, 4'b1001, ta, tb_b, 4'hF);
        check("rst priority req0", bus.req_ready, 4'b0001);
        for (int c = 0; c < 4; c++) drive(1, 4'b0000, ta, tb_b, 4'hF);

        // Random soak against a queue-of-in-flight-operations reference.
        drive(0, 4'b0000, ta, tb_b, 4'hF);
        mptr = N - 1;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            bit     head_out;
            bit     stall;
            int     win;
            int     t;
            int     idx;
            logic [3:0] e_rv;
            logic [3:0] e_rdy;
            v = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                rr[i] = ($urandom_range(0, 3) != 0);
                ra[i*21 +: 21] = 21'($urandom);
                rb[i*14 +: 14] = 14'($urandom);
            end
            drive(1, v, ra, rb, rr);

            head_out = (q.size() > 0) && (q[0].age == L);
            t = head_out ? q[0].tag : 0;
            e_rv  = head_out ? (4'b0001 << t) : 4'b0000;
            stall = head_out && !rr[t[1:0]];
            win = -1;
            if (!stall) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (mptr + k) % N;
                    if (win < 0 && v[idx[1:0]]) win = idx;
                end
            end
            e_rdy = (win >= 0) ? (4'b0001 << win) : 4'b0000;

            check("soak req_ready", bus.req_ready, e_rdy);
            check("soak rsp_valid", bus.rsp_valid, e_rv);
            check("soak mul_ce", bus.mul_ce, !stall);
            check("soak busy", bus.busy, q.size() > 0);
            if (head_out) check("soak rsp_p", bus.rsp_p, p35(q[0].prod));

            if (!stall) begin
                if (head_out) void'(q.pop_front());
                foreach (q[j]) q[j].age++;
                if (win >= 0) begin
                    q.push_back('{win, longint'(smul(ra[win*21 +: 21], rb[win*14 +: 14])), 1});
                    mptr = win;
                    gcnt[win]++;
                end
            end
        end
        for (int i = 0; i < N; i++)
            check($sformatf("soak starvation req%0d", i), gcnt[i] > 500, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/infer_mul_arb.md
# infer_mul_arb

Round-robin scheduler that shares one pipelined signed 21×14 multiplier core (infer_mul_mul_21s_14s_35_4_1, clock-enable gated, no reset) between N_REQ requesters. It accepts one operand pair per cycle from the winning requester and drives the core's din0/din1/ce. It carries a requester tag alongside the core pipeline and routes each 35-bit product back to its originator. A blocked consumer stalls the whole core through ce.

## Interface
- N_REQ, 4, number of requesters (2..8)
- IDW, 2, tag width; must satisfy 2^IDW >= N_REQ
- MUL_LAT, 3, ce-enabled edges from din sampled to dout valid; must match the core
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester operand valid
- req_a  in  21*N_REQ  signed multiplicand; requester i in bits [21i+20:21i]
- req_b  in  14*N_REQ  signed multiplier; requester i in bits [14i+13:14i]
- req_ready  out  N_REQ  one-hot grant; transfer when req_valid[i]&req_ready[i]
- rsp_valid  out  N_REQ  one-hot product valid for requester i
- rsp_p  out  35  signed product (shared bus, qualified by rsp_valid)
- rsp_ready  in  N_REQ  per-requester consumer ready
- mul_ce  out  1  core clock enable
- mul_din0  out  21  core operand a
- mul_din1  out  14  core operand b
- mul_dout  in  35  core product
- busy  out  1  any valid entry in the tag pipeline

## Operation
- Tag pipeline: MUL_LAT stages of {vld, tag[IDW-1:0]}. It advances only when mul_ce=1, in lockstep with the core. Stage MUL_LAT-1 is the output stage (out_vld, out_tag).
- Stall: mul_ce = !(out_vld & !rsp_ready[out_tag]). This is combinational.
- Arbitration: done only when mul_ce=1. Among req_valid bits, grant the first index found searching from ptr+1 upward, modulo N_REQ.
  - req_ready = one-hot of the winner; req_ready is 0 when no request is valid or mul_ce=0.
  - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- On grant of i:
  - mul_din0 = req_a[i], mul_din1 = req_b[i].
  - Stage 0 captures {1, i}.
  - ptr <= i.
- No grant with mul_ce=1:
  - mul_din0/mul_din1 = 0.
  - Stage 0 captures vld=0 (bubble).
  - ptr holds.
- mul_ce=0: the whole tag pipeline and ptr hold; core holds.
- Response:
  - rsp_valid[i] = out_vld & (out_tag==i).
  - rsp_p = mul_dout, passed through unmodified. The product is full precision: 21s×14s → 35s, so no overflow is possible.
  - The response completes when rsp_valid[i]&rsp_ready[i].
- rsp_p is don't-care when rsp_valid=0; the core holds stale data during bubbles.
- busy = OR of all stage vld bits.
- Requester indices >= N_REQ never occur in tags.

## Timing
- Reset (reset=0, asynchronous), all outputs as long as reset is held:
  - all vld=0 and ptr=N_REQ-1, so requester 0 has first priority after reset.
  - rsp_valid=0, busy=0, req_ready=0 while reset is asserted.
  - mul_ce=1, mul_din0=mul_din1=0.
- Reset release: arbitration is live in the first cycle after deassertion.
- Latency: grant in cycle t → rsp_valid in cycle t+MUL_LAT (t+3 by default) if no stall intervenes. Each stalled cycle adds one cycle.
- Throughput: one grant per cycle with no bubbles while all consumers are ready.
- Simultaneous retire and issue: out_vld with rsp_ready=1 gives mul_ce=1, so a new grant is allowed in the same cycle.
- Stall entry: the cycle in which out_vld & !rsp_ready[out_tag] holds has mul_ce=0 and no grant. rsp_valid and rsp_p are held stable until ready.
- Reset mid-operation:
  - in-flight products are discarded and no rsp_valid is issued for them.
  - the core contents are stale but masked by vld=0.
- Single requester: a continuously valid requester is granted every cycle; ptr keeps selecting it.
- Fairness: with all N_REQ requesting continuously, each is granted exactly once per N_REQ consecutive grants.

## Test plan
- Reset then single op: in cycle 1 req0 presents a=-1048576 (21-bit min), b=-8192. req_ready[0]=1 in cycle 1. rsp_valid[0]=1 in cycle 4 with rsp_p=8589934592.
- Round-robin: req0..3 held valid with a=i+1, b=100 for 8 cycles. Grant order is 0,1,2,3,0,1,2,3. Responses follow in the same order at +3 cycles with p=100,200,300,400.
- Backpressure:
  - Stimulus: back-to-back ops from req1 and req2; hold rsp_ready[1]=0 for 5 cycles once rsp_valid[1] rises.
  - mul_ce=0 for those 5 cycles; req_ready=0; rsp_valid[1] and rsp_p are stable.
  - After release: req1's response completes, then req2's response appears next cycle; no loss or duplication.
- Bubbles: a single request every 3rd cycle from req3 with b=0, a=12345. Each response has p=0, rsp_valid asserts only 3 cycles after its grant, and busy drops after the last one.
- Async reset mid-flight: three ops issued, then reset pulsed low for a partial cycle. No rsp_valid ever fires for them. busy=0 immediately. The next grant goes to req0 even if req2 last won.
- Random soak: random req_valid/rsp_ready on 4 requesters. Check the following with a scoreboard:
  - every product = a*b;
  - per-requester order is preserved;
  - there is no starvation over 10k cycles.
